// File: rtl/lshift_8_pipe.sv
// rtl/lshift_8_pipe.sv - three-stage pipelined 8-bit left barrel shifter with valid/ready handshakes
module lshift_8_pipe #(
  parameter bit ROTATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out
);

  // Fixed-distance left shift; the rotate variant folds the bits shifted out back into the LSBs.
  function automatic logic [7:0] shl_k(input logic [7:0] x, input int unsigned k);
    logic [15:0] w;
    w = {x, x} << k;
    return ROTATE ? w[15:8] : (x << k);
  endfunction

  logic       v0_q, v0_d;
  logic [7:0] data0_q, data0_d;
  logic [2:0] sel0_q, sel0_d;

  logic       v1_q, v1_d;
  logic [7:0] data1_q, data1_d;
  logic [1:0] sel1_q, sel1_d;

  logic       v2_q, v2_d;
  logic [7:0] data2_q, data2_d;

  logic       ld0, ld1, ld2;
  logic [7:0] data1_by2;

  // A stage may load when it is empty or its contents move on this same cycle.
  always_comb begin
    ld2      = !v2_q || out_ready;
    ld1      = !v1_q || ld2;
    ld0      = !v0_q || ld1;
    in_ready = rst_n && ld0;
  end

  always_comb begin
    v0_d      = v0_q;
    data0_d   = data0_q;
    sel0_d    = sel0_q;
    v1_d      = v1_q;
    data1_d   = data1_q;
    sel1_d    = sel1_q;
    v2_d      = v2_q;
    data2_d   = data2_q;
    data1_by2 = sel1_q[0] ? shl_k(data1_q, 2) : data1_q;

    if (ld0) begin
      v0_d = in_valid;
      if (in_valid) begin
        data0_d = data;
        sel0_d  = sel;
      end
    end

    if (ld1) begin
      v1_d = v0_q;
      if (v0_q) begin
        data1_d = sel0_q[0] ? shl_k(data0_q, 1) : data0_q;
        sel1_d  = sel0_q[2:1];
      end
    end

    // The last stage applies both the by-2 and by-4 steps.
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = sel1_q[1] ? shl_k(data1_by2, 4) : data1_by2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      data0_q <= 8'h00;
      sel0_q  <= 3'd0;
      v1_q    <= 1'b0;
      data1_q <= 8'h00;
      sel1_q  <= 2'd0;
      v2_q    <= 1'b0;
      data2_q <= 8'h00;
    end else begin
      v0_q    <= v0_d;
      data0_q <= data0_d;
      sel0_q  <= sel0_d;
      v1_q    <= v1_d;
      data1_q <= data1_d;
      sel1_q  <= sel1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
    end
  end

  assign out_valid = v2_q;
  assign out       = data2_q;

endmodule
